rst_sequencer: RTL and testbench

Reset sequencer between the PLL and the design logic. It takes the raw, asynchronous PLL `locked` flag and synchronizes it into `clk`. It then requires the flag to stay stable for a programmable time before releasing a set of staged, registered, active-high reset outputs in a fixed order. Loss of lock at any point re-asserts all resets immediately and is counted. Downstream logic uses `stage_rst[k]` and `ready` as its reset and run qualifiers instead of gating on `pll_locked` directly.

---
 rtl/rst_sequencer.sv | 156 +++++++++++++++
 tb/tb_rst_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/rst_sequencer.sv
// rst_sequencer: PLL lock synchronizer and staged reset release.
// Synchronizes the raw pll_locked flag into clk, waits for LOCK_STABLE
// consecutive locked cycles, then releases stage_rst[0..N_STAGES-1] in index
// order every STAGE_DELAY cycles and finally raises ready. Any loss of the
// synchronized lock re-asserts all stages at once and bumps a saturating count.
// Ports:
//   clk           - PLL output clock
//   rst           - asynchronous active-high reset
//   pll_locked    - raw lock flag, asynchronous to clk
//   cnt_clr       - synchronous clear of lock_loss_cnt
//   stage_rst     - registered active-high per-stage resets, bit 0 released first
//   ready         - registered, high once all stages are out of reset plus one delay
//   lock_loss_cnt - registered saturating count of lock-loss events
module rst_sequencer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_STABLE = 1024,
  parameter int unsigned STAGE_DELAY = 16,
  parameter int unsigned N_STAGES    = 3,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pll_locked,
  input  logic                cnt_clr,
  output logic [N_STAGES-1:0] stage_rst,
  output logic                ready,
  output logic [CNT_W-1:0]    lock_loss_cnt
);

  // Stable counter only needs to reach LOCK_STABLE-1; delay counter STAGE_DELAY-1.
  localparam int unsigned STB_W = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
  localparam int unsigned DLY_W = (STAGE_DELAY > 1) ? $clog2(STAGE_DELAY) : 1;

  localparam logic [STB_W-1:0]    STB_LAST    = STB_W'(LOCK_STABLE - 1);
  localparam logic [DLY_W-1:0]    DLY_LAST    = DLY_W'(STAGE_DELAY - 1);
  localparam logic [N_STAGES-1:0] STAGE_ALL   = '1;
  localparam logic [N_STAGES-1:0] STAGE_FIRST = STAGE_ALL << 1;
  localparam logic [CNT_W-1:0]    CNT_MAX     = '1;

  typedef enum logic [1:0] {
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;

  state_e                 state_q, state_d;
  logic [STB_W-1:0]       stb_q, stb_d;
  logic [DLY_W-1:0]       dly_q, dly_d;
  logic [N_STAGES-1:0]    stage_q, stage_d;
  logic                   ready_q, ready_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   loss_c;

  assign locked_s = sync_q[SYNC_STAGES-1];

  // Next-state logic; stages release by shifting a zero in from bit 0.
  always_comb begin
    state_d = state_q;
    stb_d   = stb_q;
    dly_d   = dly_q;
    stage_d = stage_q;
    ready_d = ready_q;
    loss_c  = 1'b0;

    if ((state_q != S_WAIT_LOCK) && !locked_s) begin
      loss_c  = 1'b1;
      state_d = S_WAIT_LOCK;
      stb_d   = '0;
      dly_d   = '0;
      stage_d = STAGE_ALL;
      ready_d = 1'b0;
    end else begin
      unique case (state_q)
        S_WAIT_LOCK: begin
          if (locked_s) begin
            if (LOCK_STABLE == 1) begin
              state_d = S_RELEASE;
              stage_d = STAGE_FIRST;
              dly_d   = '0;
            end else begin
              state_d = S_STABLE;
              stb_d   = STB_W'(1);
            end
          end
        end
        S_STABLE: begin
          if (stb_q == STB_LAST) begin
            state_d = S_RELEASE;
            stage_d = STAGE_FIRST;
            stb_d   = '0;
            dly_d   = '0;
          end else begin
            stb_d = stb_q + STB_W'(1);
          end
        end
        S_RELEASE: begin
          if (dly_q == DLY_LAST) begin
            dly_d = '0;
            // All stages already out: this wrap is the final delay before ready.
            if (stage_q == '0) begin
              ready_d = 1'b1;
              state_d = S_RUN;
            end else begin
              stage_d = stage_q << 1;
            end
          end else begin
            dly_d = dly_q + DLY_W'(1);
          end
        end
        S_RUN: begin
          stage_d = '0;
          ready_d = 1'b1;
        end
        default: state_d = S_WAIT_LOCK;
      endcase
    end

    // A clear coinciding with a loss leaves exactly that loss counted.
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = loss_c ? CNT_W'(1) : '0;
    end else if (loss_c && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State, counters, synchronizer and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= S_WAIT_LOCK;
      stb_q   <= '0;
      dly_q   <= '0;
      stage_q <= STAGE_ALL;
      ready_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pll_locked};
      state_q <= state_d;
      stb_q   <= stb_d;
      dly_q   <= dly_d;
      stage_q <= stage_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stage_rst     = stage_q;
  assign ready         = ready_q;
  assign lock_loss_cnt = cnt_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: scoreboard bench for rst_sequencer.
// The stimulus side drives inputs on the falling edge and pushes the expected
// outputs for the next rising edge; a separate monitor pops and compares them.
// The reference model tracks only how long the synchronized lock has been held.
module tb_rst_sequencer;

  localparam int SYNC_STAGES = 2;
  localparam int LOCK_STABLE = 8;
  localparam int STAGE_DELAY = 4;
  localparam int N_STAGES    = 3;
  localparam int CNT_W       = 2;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;
  localparam int RUN_CAP     = LOCK_STABLE + N_STAGES * STAGE_DELAY + 1;

  typedef struct packed {
    logic [N_STAGES-1:0] st;
    logic                rdy;
    logic [CNT_W-1:0]    cnt;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                pll_locked = 1'b0;
  logic                cnt_clr = 1'b0;
  logic [N_STAGES-1:0] stage_rst;
  logic                ready;
  logic [CNT_W-1:0]    lock_loss_cnt;

  exp_t exp_q[$];
  bit   hist_q[$];
  int   run_len = 0;
  int   m_cnt   = 0;
  int   errors  = 0;
  int   checks  = 0;
  int   cyc     = 0;
  bit   running = 1'b0;

  rst_sequencer #(
    .SYNC_STAGES(SYNC_STAGES),
    .LOCK_STABLE(LOCK_STABLE),
    .STAGE_DELAY(STAGE_DELAY),
    .N_STAGES   (N_STAGES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .cnt_clr      (cnt_clr),
    .stage_rst    (stage_rst),
    .ready        (ready),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk = ~clk;

  // Outputs follow from the length of the current synchronized-locked run.
  function automatic exp_t model_out();
    exp_t e;
    int   t;
    e.st  = '1;
    e.rdy = 1'b0;
    e.cnt = CNT_W'(m_cnt);
    if (run_len >= LOCK_STABLE) begin
      t = run_len - LOCK_STABLE;
      for (int k = 0; k < N_STAGES; k++) e.st[k] = (t < k * STAGE_DELAY);
      e.rdy = (t >= N_STAGES * STAGE_DELAY);
    end
    return e;
  endfunction

  // Drive one cycle of inputs and predict the outputs after the next edge.
  task automatic step(input bit pll, input bit clr, input bit r);
    bit ls;
    bit loss;
    @(negedge clk);
    pll_locked = pll;
    cnt_clr    = clr;
    rst        = r;
    if (r) begin
      hist_q.delete();
      for (int i = 0; i < SYNC_STAGES; i++) hist_q.push_back(1'b0);
      run_len = 0;
      m_cnt   = 0;
    end else begin
      ls = hist_q.pop_front();
      hist_q.push_back(pll);
      loss = !ls && (run_len > 0);
      if (ls) begin
        if (run_len < RUN_CAP) run_len++;
      end else begin
        run_len = 0;
      end
      if (clr) m_cnt = loss ? 1 : 0;
      else if (loss && (m_cnt < CNT_MAX)) m_cnt++;
    end
    exp_q.push_back(model_out());
    running = 1'b1;
  endtask

  task automatic hold(input bit pll, input int n);
    repeat (n) step(pll, 1'b0, 1'b0);
  endtask

  // Reset must take effect with no clock edge in between.
  task automatic async_rst_check();
    step(pll_locked, 1'b0, 1'b1);
    #1;
    checks++;
    if (stage_rst !== '1 || ready !== 1'b0 || lock_loss_cnt !== '0) begin
      errors++;
      $display("FAIL async_rst: got stage_rst=%b ready=%b cnt=%0d, want stage_rst=111 ready=0 cnt=0",
               stage_rst, ready, lock_loss_cnt);
    end
  endtask

  // Monitor: compare every rising edge against the scoreboard and check ordering.
  initial begin
    exp_t e;
    exp_t got;
    bit   bad_order;
    forever begin
      @(posedge clk);
      #1;
      if (running) begin
        cyc++;
        got.st  = stage_rst;
        got.rdy = ready;
        got.cnt = lock_loss_cnt;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty cyc=%0d: got stage_rst=%b ready=%b cnt=%0d with nothing expected",
                   cyc, got.st, got.rdy, got.cnt);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL outputs cyc=%0d: got stage_rst=%b ready=%b cnt=%0d, want stage_rst=%b ready=%b cnt=%0d",
                     cyc, got.st, got.rdy, got.cnt, e.st, e.rdy, e.cnt);
          end
        end
        bad_order = 1'b0;
        for (int k = 1; k < N_STAGES; k++)
          if (stage_rst[k] == 1'b0 && stage_rst[k-1] != 1'b0) bad_order = 1'b1;
        if (ready && stage_rst != '0) bad_order = 1'b1;
        checks++;
        if (bad_order) begin
          errors++;
          $display("FAIL ordering cyc=%0d: got stage_rst=%b ready=%b, want in-order release",
                   cyc, stage_rst, ready);
        end
      end
    end
  end

  initial begin
    // Reset
    repeat (3) step(1'b0, 1'b0, 1'b1);
    hold(1'b0, 3);
    // Clean lock
    hold(1'b1, 30);
    // Loss in RUN, then relock
    hold(1'b0, int'($urandom_range(1, 4)));
    hold(1'b1, 30);
    // Glitch during STABLE
    hold(1'b0, 4);
    hold(1'b1, 5);
    hold(1'b0, 3);
    hold(1'b1, 30);
    // Saturation: five loss events
    for (int i = 0; i < 5; i++) begin
      hold(1'b1, int'($urandom_range(3, 25)));
      hold(1'b0, int'($urandom_range(1, 3)));
    end
    hold(1'b1, 6);
    // Clear alone
    step(1'b1, 1'b1, 1'b0);
    hold(1'b1, 4);
    // Clear on the same edge as a loss
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    hold(1'b0, 2);
    // Async reset mid-release
    hold(1'b1, 12);
    async_rst_check();
    step(1'b1, 1'b0, 1'b1);
    hold(1'b1, 30);
    // Random lock/unlock traffic with occasional clears
    for (int i = 0; i < 25; i++) begin
      int n;
      n = int'($urandom_range(1, 30));
      repeat (n) step(1'b1, ($urandom_range(0, 15) == 0), 1'b0);
      n = int'($urandom_range(1, 4));
      repeat (n) step(1'b0, ($urandom_range(0, 7) == 0), 1'b0);
    end
    hold(1'b1, 30);

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
